// File: rtl/mem_access_unit.sv
// Load/store initiator for the data memory port: one transaction at a time, lane-aligned stores, extended loads.
// Optional feature macro: MEM_ACCESS_MISALIGN_CHECK_EN (defined = misaligned requests are rejected with resp_misalign).
module mem_access_unit #(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic [63:0] mem_raddr,
  output logic        mem_ren,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen
);

  localparam int unsigned CW = $clog2(MEM_LAT + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          wen_q;
  logic          uns_q;
  logic [63:0]   addr_q;
  logic [1:0]    size_q;
  logic [63:0]   wdata_q;
  logic          mem_ren_q;
  logic          mem_wen_q;
  logic [63:0]   resp_rdata_q;
  logic          resp_mis_q;

  logic          req_mis;
  logic [7:0]    lane_mask;
  logic [63:0]   ld_shift;
  logic [63:0]   ld_ext;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic [2:0] align_bits;
  always_comb begin
    align_bits = 3'b000;
    unique case (req_size)
      2'd0: align_bits = 3'b000;
      2'd1: align_bits = 3'b001;
      2'd2: align_bits = 3'b011;
      2'd3: align_bits = 3'b111;
      default: align_bits = 3'b000;
    endcase
    req_mis = |(req_addr[2:0] & align_bits);
  end
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    lane_mask = 8'h00;
    unique case (size_q)
      2'd0: lane_mask = 8'h01;
      2'd1: lane_mask = 8'h03;
      2'd2: lane_mask = 8'h0F;
      2'd3: lane_mask = 8'hFF;
      default: lane_mask = 8'h00;
    endcase
  end

  // Right shift zero-fills the high bytes, which is also the defined result for unchecked misaligned loads.
  assign ld_shift = mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_ext = '0;
    unique case (size_q)
      2'd0: ld_ext = uns_q ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'd1: ld_ext = uns_q ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_ext = uns_q ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      2'd3: ld_ext = ld_shift;
      default: ld_ext = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wen_q        <= req_wen;
            uns_q        <= req_unsigned;
            addr_q       <= req_addr;
            size_q       <= req_size;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            if (req_mis) begin
              resp_mis_q <= 1'b1;
              state_q    <= RESP;
            end else begin
              resp_mis_q <= 1'b0;
              mem_ren_q  <= !req_wen;
              mem_wen_q  <= req_wen;
              state_q    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_wen_q <= 1'b0;
          if (MEM_LAT == 0) begin
            mem_ren_q    <= 1'b0;
            resp_rdata_q <= wen_q ? '0 : ld_ext;
            state_q      <= RESP;
          end else begin
            cnt_q   <= CW'(MEM_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            mem_ren_q    <= 1'b0;
            resp_rdata_q <= wen_q ? '0 : ld_ext;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_misalign = resp_mis_q;

  // Buses are qualified by the registered strobes so they read 0 whenever no access is in flight.
  assign mem_ren   = mem_ren_q;
  assign mem_raddr = mem_ren_q ? {addr_q[63:3], 3'b000} : '0;
  assign mem_wen   = mem_wen_q;
  assign mem_waddr = mem_wen_q ? {addr_q[63:3], 3'b000} : '0;
  assign mem_wdata = mem_wen_q ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
  assign mem_wmask = mem_wen_q ? (lane_mask << addr_q[2:0]) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: two instances (MEM_LAT=0 and MEM_LAT=3) run the same request stream.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b1;
  logic [63:0] mem_rdata = '0;

  logic        rqr [2];
  logic        rv  [2];
  logic [63:0] rd  [2];
  logic        mis [2];
  logic [63:0] raddr [2];
  logic        ren [2];
  logic [63:0] waddr [2];
  logic [63:0] wdata [2];
  logic [7:0]  wmask [2];
  logic        wen [2];

  always #5 clock = ~clock;

  mem_access_unit #(.MEM_LAT(0)) u_lat0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rqr[0]), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_misalign(mis[0]),
    .mem_raddr(raddr[0]), .mem_ren(ren[0]), .mem_rdata(mem_rdata),
    .mem_waddr(waddr[0]), .mem_wdata(wdata[0]), .mem_wmask(wmask[0]), .mem_wen(wen[0])
  );

  mem_access_unit #(.MEM_LAT(3)) u_lat3 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rqr[1]), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_misalign(mis[1]),
    .mem_raddr(raddr[1]), .mem_ren(ren[1]), .mem_rdata(mem_rdata),
    .mem_waddr(waddr[1]), .mem_wdata(wdata[1]), .mem_wmask(wmask[1]), .mem_wen(wen[1])
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
  } resp_t;

  resp_t sb [2][$];

  int n_checks = 0;
  int n_errors = 0;

  int ren_cnt [2];
  int wen_cnt [2];
  int exp_ren [2];
  int exp_wen [2];
  int arr_exp [2];
  int seen    [2];
  int done_st [2];
  logic [63:0] exp_addr;
  logic [63:0] exp_wd;
  logic [7:0]  exp_wm;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_load(input logic [63:0] word, input int off, input int sz, input logic uns);
    logic [63:0] r;
    int nb;
    r  = '0;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) r[8*i +: 8] = word[8*(off+i) +: 8];
    if (!uns && sz != 3 && r[8*nb-1])
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] m_mask(input int off, input int sz);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < (1 << sz); i++)
      if (off + i < 8) m[off+i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] d, input int off);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 8; j++)
      if (j >= off) w[8*j +: 8] = d[8*(j-off) +: 8];
    return w;
  endfunction

  function automatic logic m_mis(input int off, input int sz);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    return (off % (1 << sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic mon(input int d);
    resp_t front;
    string p;
    p = (d == 0) ? "l0_" : "l3_";
    if (done_st[d] == 2) return;
    if (done_st[d] == 1) begin
      check_eq({p, "idle_ready"}, {63'd0, rqr[d]}, 64'd1);
      check_eq({p, "idle_valid"}, {63'd0, rv[d]}, 64'd0);
      done_st[d] = 2;
      return;
    end
    check_eq({p, "busy_ready"}, {63'd0, rqr[d]}, 64'd0);
    if (ren[d]) begin
      ren_cnt[d]++;
      check_eq({p, "raddr"}, raddr[d], {exp_addr[63:3], 3'b000});
    end
    if (wen[d]) begin
      wen_cnt[d]++;
      check_eq({p, "waddr"}, waddr[d], {exp_addr[63:3], 3'b000});
      check_eq({p, "wdata"}, wdata[d], exp_wd);
      check_eq({p, "wmask"}, {56'd0, wmask[d]}, {56'd0, exp_wm});
    end
    if (!ren[d] && !wen[d])
      check_eq({p, "bus_idle"}, raddr[d] | waddr[d] | wdata[d] | {56'd0, wmask[d]}, 64'd0);
    if (rv[d]) begin
      if (seen[d] == 0) begin
        check_eq({p, "resp_arrival"}, 64'(ren_cnt[d] + wen_cnt[d] + seen[d]) + 64'(cyc), 64'(arr_exp[d] + exp_ren[d] + exp_wen[d]));
        seen[d] = 1;
      end
      if (sb[d].size() == 0) begin
        check_eq({p, "sb_empty"}, 64'd1, 64'd0);
      end else begin
        front = sb[d][0];
        check_eq({p, "rdata"}, rd[d], front.rdata);
        check_eq({p, "misalign"}, {63'd0, mis[d]}, {63'd0, front.mis});
        if (resp_ready) begin
          void'(sb[d].pop_front());
          check_eq({p, "ren_cycles"}, 64'(ren_cnt[d]), 64'(exp_ren[d]));
          check_eq({p, "wen_cycles"}, 64'(wen_cnt[d]), 64'(exp_wen[d]));
          done_st[d] = 1;
        end
      end
    end
  endtask

  int cyc;

  task automatic run_txn(input logic w, input logic [63:0] addr, input int sz, input logic uns,
                         input logic [63:0] wd, input logic [63:0] word, input int stall_k);
    int off;
    logic m;
    resp_t e;
    off = int'(addr[2:0]);
    m   = m_mis(off, sz);
    exp_addr = addr;
    exp_wd   = m_wdata(wd, off);
    exp_wm   = m_mask(off, sz);
    e.rdata  = (w || m) ? 64'd0 : m_load(word, off, sz, uns);
    e.mis    = m;
    for (int d = 0; d < 2; d++) begin
      int lat;
      lat = (d == 0) ? 0 : 3;
      arr_exp[d] = m ? 1 : 2 + lat;
      exp_ren[d] = (m || w) ? 0 : lat + 1;
      exp_wen[d] = (!m && w) ? 1 : 0;
      ren_cnt[d] = 0;
      wen_cnt[d] = 0;
      seen[d]    = 0;
      done_st[d] = 0;
      sb[d].push_back(e);
    end
    @(negedge clock);
    check_eq("l0_accept_ready", {63'd0, rqr[0]}, 64'd1);
    check_eq("l3_accept_ready", {63'd0, rqr[1]}, 64'd1);
    req_valid = 1'b1; req_wen = w; req_addr = addr; req_size = 2'(sz);
    req_unsigned = uns; req_wdata = wd; mem_rdata = word;
    resp_ready = (stall_k == 0);
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      resp_ready = (k >= stall_k);
      cyc = k;
      #1;
      mon(0);
      mon(1);
      if (done_st[0] == 2 && done_st[1] == 2) break;
    end
    check_eq("l0_complete", 64'(done_st[0]), 64'd2);
    check_eq("l3_complete", 64'(done_st[1]), 64'd2);
    resp_ready = 1'b1;
  endtask

  initial begin
    int sz;
    int off;
    // Reset values
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_ready", {63'd0, rqr[d]}, 64'd1);
      check_eq("rst_resp", {62'd0, rv[d], mis[d]}, 64'd0);
      check_eq("rst_rdata", rd[d], 64'd0);
      check_eq("rst_mem", raddr[d] | waddr[d] | wdata[d] | {54'd0, wmask[d], ren[d], wen[d]}, 64'd0);
    end
    reset_n = 1'b1;

    run_txn(1'b1, 64'h80000008, 3, 1'b0, 64'h1122334455667788, 64'd0, 0);
    run_txn(1'b1, 64'h80000003, 0, 1'b0, 64'h00000000000000AB, 64'd0, 0);
    run_txn(1'b0, 64'h80000005, 0, 1'b0, 64'd0, 64'h0000800000000000, 0);
    run_txn(1'b0, 64'h80000005, 0, 1'b1, 64'd0, 64'h0000800000000000, 0);
    run_txn(1'b0, 64'h80000006, 1, 1'b0, 64'd0, 64'h7FFF000000000000, 0);
    run_txn(1'b0, 64'h80000004, 2, 1'b0, 64'd0, 64'h8000000000000000, 0);
    run_txn(1'b0, 64'h80000010, 3, 1'b1, 64'd0, 64'h8000000000000001, 0);
    run_txn(1'b0, 64'h80000002, 2, 1'b0, 64'd0, 64'hDEADBEEFCAFEF00D, 0);
    run_txn(1'b1, 64'h80000005, 3, 1'b0, 64'h1122334455667788, 64'd0, 0);
    run_txn(1'b0, 64'h80000002, 1, 1'b1, 64'd0, 64'h0123456789ABCDEF, 8);

    for (int i = 0; i < 6; i++) begin
      sz  = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 7)) & ~((1 << sz) - 1);
      run_txn(1'($urandom_range(0, 1)), 64'h80001000 + 64'(8*i + off), sz, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, {$urandom, $urandom}, 0);
    end

    // Reset while the MEM_LAT=3 instance is mid-WAIT and the MEM_LAT=0 instance holds a stalled response
    @(negedge clock);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000020; req_size = 2'd3;
    req_unsigned = 1'b0; mem_rdata = 64'hCAFEBABE12345678; resp_ready = 1'b0;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_eq("pre_rst_l3_ren", {63'd0, ren[1]}, 64'd1);
    check_eq("pre_rst_l0_valid", {63'd0, rv[0]}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_l3_ren_drop", {63'd0, ren[1]}, 64'd0);
    check_eq("rst_l3_raddr", raddr[1], 64'd0);
    check_eq("rst_l0_valid_drop", {63'd0, rv[0]}, 64'd0);
    check_eq("rst_l0_rdata", rd[0], 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_eq("post_rst_no_resp", {62'd0, rv[0], rv[1]}, 64'd0);
      check_eq("post_rst_ready", {62'd0, rqr[0], rqr[1]}, 64'd3);
    end
    run_txn(1'b0, 64'h80000021, 0, 1'b0, 64'd0, 64'h000000000000F100, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
